// File: rtl/seg7_readback_decoder_pkg.sv
// Shared constants and types for the seven-segment readback decoder.
// Segment constants are active-low, bit order g..a.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_digit_lookup.sv
// Combinational map from one seven-segment pattern to its decimal digit.
// Unknown patterns give digit 0 with legal low; blank gives digit 0, legal.
module seg7_digit_lookup
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal,
  output logic       blank
);

  logic [6:0] norm;

  // Bring the input into the active-low form the table is written in.
  assign norm = (ACTIVE_LOW != 0) ? pattern : ~pattern;

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    blank = 1'b0;
    case (norm)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Recovers a binary value from a packed seven-segment word, one digit per
// cycle from the most significant field down (acc = acc*10 + digit).
//
// Handshake: a word is taken on any clock edge where in_valid && in_ready;
// the result is held on num/err/err_mask while out_valid is high and is
// released on the edge where out_valid && out_ready. No overlap: in_ready is
// low from acceptance until the result has been taken.
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int SEG_W      = 7,
  parameter int NUM_W      = 32,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGITS*SEG_W-1:0] segs_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_W-1:0]        num,
  output logic                    err,
  output logic [DIGITS-1:0]       err_mask,
  output state_t                  state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                  state_q, state_d;
  logic [DIGITS*SEG_W-1:0] word_q;
  logic [NUM_W-1:0]        acc_q;
  logic [NUM_W-1:0]        acc_next;
  logic [IDX_W-1:0]        idx_q;
  logic [DIGITS-1:0]       err_mask_q;

  logic [SEG_W-1:0]        field;
  logic [3:0]              digit;
  logic                    legal;
  logic                    blank;
  logic [3:0]              digit_eff;

  assign field = word_q[int'(idx_q)*SEG_W +: SEG_W];

  seg7_digit_lookup #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_lookup (
    .pattern(field),
    .digit  (digit),
    .legal  (legal),
    .blank  (blank)
  );

  // Blank fields (leading blanks) contribute zero to the value.
  assign digit_eff = blank ? 4'd0 : digit;
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + NUM_W'(digit_eff);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        if (idx_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      err_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q     <= segs_in;
            acc_q      <= '0;
            idx_q      <= IDX_W'(DIGITS - 1);
            err_mask_q <= '0;
          end
        end
        CONV: begin
          acc_q             <= acc_next;
          err_mask_q[idx_q] <= ~legal;
          if (idx_q != '0) idx_q <= idx_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign num      = acc_q;
  assign err_mask = err_mask_q;
  assign err      = |err_mask_q;
  assign state    = state_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder: a vector table of whole words
// plus hand-written sequences for back-to-back, stall and mid-decode reset.
module tb_seg7_readback_decoder;
  import seg7_pkg::*;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] segs_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] num;
  logic        err;
  logic [2:0]  err_mask;
  state_t      state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [20:0] segs;
    logic [31:0] num;
    logic        err;
    logic [2:0]  mask;
  } vec_t;

  vec_t vecs[8];

  seg7_readback_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .segs_in  (segs_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .num      (num),
    .err      (err),
    .err_mask (err_mask),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Presents one word in IDLE; returns #1 after the accepting edge.
  task automatic send(input logic [20:0] w);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    segs_in  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Counts edges after acceptance until out_valid; bounded at 20.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
    check("ready_after_release", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.segs);
    wait_out(lat);
    check("latency", lat, 32'd3);
    check("num", num, v.num);
    check("err", {31'd0, err}, {31'd0, v.err});
    check("err_mask", {29'd0, err_mask}, {29'd0, v.mask});
    check("ready_low_in_done", {31'd0, in_ready}, 32'd0);
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [1:0] exp_ctl[10];
    vecs[0] = '{{S1, S2, S3},          32'd123, 1'b0, 3'b000};
    vecs[1] = '{{S4, 7'b1010101, S7},  32'd407, 1'b1, 3'b010};
    vecs[2] = '{{SB, SB, S5},          32'd5,   1'b0, 3'b000};
    vecs[3] = '{{S8, S6, S0},          32'd860, 1'b0, 3'b000};
    vecs[4] = '{{S9, S0, S1},          32'd901, 1'b0, 3'b000};
    vecs[5] = '{{7'b0000001, S7, 7'b1110111}, 32'd70, 1'b1, 3'b101};
    vecs[6] = '{{SB, S4, S2},          32'd42,  1'b0, 3'b000};
    vecs[7] = '{{S9, S9, S9},          32'd999, 1'b0, 3'b000};

    // Reset with in_valid high: the word must not be taken.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    segs_in   = {S1, S2, S3};
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_num", num, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_err_mask", {29'd0, err_mask}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("no_accept_in_rst", {30'd0, state}, {30'd0, IDLE});
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back 999 then 000 with out_ready tied high.
    // exp_ctl = {in_ready, out_valid} sampled after edge E0+c.
    exp_ctl = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    out_ready = 1'b1;
    segs_in   = {S9, S9, S9};
    in_valid  = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      if (c == 0) segs_in = {S0, S0, S0};
      if (c == 5) in_valid = 1'b0;
      check($sformatf("b2b_ctl_%0d", c), {30'd0, in_ready, out_valid}, {30'd0, exp_ctl[c]});
      if (c == 3) check("b2b_num_999", num, 32'd999);
      if (c == 8) check("b2b_num_0", num, 32'd0);
    end
    out_ready = 1'b0;

    // Stall in DONE with inputs toggling.
    send({S1, S2, S3});
    wait_out(lat);
    check("stall_latency", lat, 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      segs_in  = 21'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_num", num, 32'd123);
      check("stall_err", {31'd0, err}, 32'd0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    check("stall_exit_state", {30'd0, state}, {30'd0, IDLE});

    // Reset mid-decode, then a fresh word.
    segs_in  = {S1, S2, S3};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_state", {30'd0, state}, {30'd0, IDLE});
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_num", num, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_vec('{{S0, S4, S2}, 32'd42, 1'b0, 3'b000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
